// File: rtl/input_equip.sv
// input_equip: memory-mapped capture peripheral.
// Synchronises a switch bank and a capture button and debounces the button.
// Each debounced press latches the switches and raises valid (also driven on irq).
// The CPU polls STATUS (addr 0) and reads DATA (addr 1); reads clear the flags.
module input_equip #(
  parameter int DBNC_CYCLES = 1_000_000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RD_en,
  input  logic        addr,
  input  logic [31:0] sw_in,
  input  logic        btn_in,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  logic [31:0]      sw_meta_q, sw_sync_q;
  logic             btn_meta_q, btn_sync_q;
  logic             btn_stable_q, btn_stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             press;

  // Debounce: the button must disagree with the stable value for DBNC_CYCLES
  // consecutive cycles before the new level is accepted.
  always_comb begin
    btn_stable_d = btn_stable_q;
    cnt_d        = cnt_q;
    if (btn_sync_q == btn_stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      btn_stable_d = btn_sync_q;
      cnt_d        = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign press = btn_sync_q && !btn_stable_q && (cnt_q == CNT_LAST);

  // Capture and read side effects; a capture on the same edge overrides any clear.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (RD_en && addr)  valid_d   = 1'b0;
    if (RD_en && !addr) overrun_d = 1'b0;
    if (press) begin
      data_d  = sw_sync_q;
      valid_d = 1'b1;
      if (valid_q) overrun_d = 1'b1;
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      cnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sw_meta_q    <= sw_in;
      sw_sync_q    <= sw_meta_q;
      btn_meta_q   <= btn_in;
      btn_sync_q   <= btn_meta_q;
      btn_stable_q <= btn_stable_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // Read mux is combinational on addr.
  always_comb begin
    dout = addr ? data_q : {30'b0, overrun_q, valid_q};
  end

  assign irq = valid_q;

endmodule

// File: tb/tb_input_equip.sv
// Directed bench for input_equip with a short debounce window (4 cycles).
module tb_input_equip;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RD_en = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] sw_in = '0;
  logic        btn_in = 1'b0;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  input_equip #(.DBNC_CYCLES(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .RD_en  (RD_en),
    .addr   (addr),
    .sw_in  (sw_in),
    .btn_in (btn_in),
    .dout   (dout),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n posedges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic read_strobe(input logic a);
    addr  = a;
    RD_en = 1'b1;
    step(1);
    RD_en = 1'b0;
  endtask

  initial begin
    // 1 reset with button held
    rst = 1'b1; sw_in = 32'hFFFF_FFFF; btn_in = 1'b1;
    step(2);
    rd_chk("rst_status", 1'b0, 32'h0);
    rd_chk("rst_data", 1'b1, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    step(5);
    chk("rst_rel_irq_e5", {31'b0, irq}, 32'h0);
    step(1);
    chk("rst_rel_irq_e6", {31'b0, irq}, 32'h1);
    rd_chk("rst_rel_data", 1'b1, 32'hFFFF_FFFF);
    btn_in = 1'b0;
    step(8);
    read_strobe(1'b1);
    rd_chk("clr_status", 1'b0, 32'h0);

    // 2 clean press
    sw_in = 32'hDEAD_BEEF; btn_in = 1'b1;
    step(5);
    chk("press_irq_e5", {31'b0, irq}, 32'h0);
    step(1);
    chk("press_irq_e6", {31'b0, irq}, 32'h1);
    rd_chk("press_data", 1'b1, 32'hDEAD_BEEF);
    rd_chk("press_status", 1'b0, 32'h1);
    step(4);
    btn_in = 1'b0;
    read_strobe(1'b1);
    chk("read_irq", {31'b0, irq}, 32'h0);
    rd_chk("read_data", 1'b1, 32'hDEAD_BEEF);
    step(8);

    // 3 bounce rejection
    sw_in = 32'h0BAD_0BAD;
    btn_in = 1'b1; step(3);
    btn_in = 1'b0; step(2);
    btn_in = 1'b1; step(3);
    btn_in = 1'b0; step(10);
    rd_chk("bounce_status", 1'b0, 32'h0);
    rd_chk("bounce_data", 1'b1, 32'hDEAD_BEEF);
    read_strobe(1'b1);
    rd_chk("idle_read_status", 1'b0, 32'h0);
    rd_chk("idle_read_data", 1'b1, 32'hDEAD_BEEF);

    // 4 overrun
    sw_in = 32'h1111_1111; btn_in = 1'b1; step(8);
    btn_in = 1'b0; step(8);
    rd_chk("ovr_first_status", 1'b0, 32'h1);
    sw_in = 32'h2222_2222; btn_in = 1'b1; step(8);
    rd_chk("ovr_status", 1'b0, 32'h3);
    rd_chk("ovr_data", 1'b1, 32'h2222_2222);
    read_strobe(1'b0);
    rd_chk("ovr_clr_status", 1'b0, 32'h1);
    btn_in = 1'b0; step(8);

    // 5 capture colliding with a DATA read
    sw_in = 32'h0000_00A5; btn_in = 1'b1;
    step(5);
    rd_chk("coll_pre_status", 1'b0, 32'h1);
    read_strobe(1'b1);
    rd_chk("coll_status", 1'b0, 32'h3);
    rd_chk("coll_data", 1'b1, 32'h0000_00A5);
    btn_in = 1'b0; step(8);

    // 6 reset mid-debounce
    sw_in = 32'h0000_5A5A; btn_in = 1'b1;
    step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    rd_chk("mid_rst_status", 1'b0, 32'h0);
    rd_chk("mid_rst_data", 1'b1, 32'h0);
    step(5);
    chk("mid_rst_irq_e5", {31'b0, irq}, 32'h0);
    step(1);
    chk("mid_rst_irq_e6", {31'b0, irq}, 32'h1);
    rd_chk("mid_rst_cap_data", 1'b1, 32'h0000_5A5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
